// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Each digit owns a CLK_DIV-cycle slot. The first BLANK_CYC cycles of every
// slot are blanked for anti-ghosting. New display data is staged in a
// pending register and becomes active only at frame boundaries.
// Optional build macro: SEG_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        din_valid,
  output logic [3:0]  data_disp,
  output logic [3:0]  sel,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      act_val_q, act_val_d;
  logic [3:0]       act_dp_q, act_dp_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_flag_q, pend_flag_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       data_disp_q, data_disp_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             tick;
  logic             boundary;
  logic             blank;
  logic [3:0]       en;

  // Slot timing, digit index and pending/active data staging
  always_comb begin
    tick     = (div_q == DIV_LAST);
    boundary = tick && (idx_q == 2'd3);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;

    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;

    if (boundary) begin
      // A strobe landing on the boundary bypasses pending so it is shown in
      // the very next digit-0 slot; any older pending value is superseded.
      if (din_valid) begin
        act_val_d = din;
        act_dp_d  = dp_in;
      end else if (pend_flag_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (din_valid) begin
      pend_val_d  = din;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // Next values of the registered display outputs, from this cycle's state
  always_comb begin
    blank = (div_q < BLANK_LIM);
    en    = 4'b0001 << idx_q;
`ifdef SEG_ZERO_BLANK_EN
    begin
      logic [3:0] lead;
      lead    = '0;
      lead[3] = (act_val_q[15:12] == 4'h0) && !act_dp_q[3];
      lead[2] = (act_val_q[15:8]  == 8'h0) && !act_dp_q[2];
      lead[1] = (act_val_q[15:4]  == 12'h0) && !act_dp_q[1];
      en      = en & ~lead;
    end
`endif
    sel_d         = blank ? '1 : ~en;
    data_disp_d   = act_val_q[{idx_q, 2'b00} +: 4];
    dp_d          = (sel_d == 4'hF) ? 1'b0 : act_dp_q[idx_q];
    frame_start_d = boundary;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      idx_q         <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_flag_q   <= 1'b0;
      sel_q         <= '1;
      data_disp_q   <= '0;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pend_flag_q   <= pend_flag_d;
      sel_q         <= sel_d;
      data_disp_q   <= data_disp_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign data_disp   = data_disp_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYC=2).
// Stimulus pushes the value each frame is expected to display; the monitor
// pops one entry per frame and checks every output cycle of that frame.
module tb_seg_scan_ctrl;
  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        din_valid;
  logic [3:0]  data_disp;
  logic [3:0]  sel;
  logic        dp;
  logic        frame_start;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .din_valid(din_valid),
    .data_disp(data_disp), .sel(sel), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
  } frame_t;

  frame_t      exp_q[$];
  frame_t      cur;
  bit          in_frame = 1'b0;
  int unsigned k = 0;
  int unsigned m = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        rst_d = 1'b0;

  always @(posedge clk) rst_d <= rst;

  // Expected {sel, data_disp, dp} for output cycle j of a frame (j=0..31)
  function automatic logic [8:0] model(input frame_t f, input int unsigned j);
    int unsigned d;
    int unsigned ix;
    logic [15:0] v;
    logic [3:0]  nib;
    logic [3:0]  en;
    logic [3:0]  s;
    logic        p;
    d   = j % CLK_DIV;
    ix  = j / CLK_DIV;
    v   = f.val;
    nib = v[ix*4 +: 4];
    en  = 4'b0001 << ix;
`ifdef SEG_ZERO_BLANK_EN
    if (ix != 0 && (v >> (4 * ix)) == 16'h0 && !f.dpv[ix]) en = 4'b0000;
`endif
    s = (d < BLANK_CYC) ? 4'hF : ~en;
    p = (s == 4'hF) ? 1'b0 : f.dpv[ix];
    return {s, nib, p};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t (frame cycle %0d): got %h, expected %h", name, $time, k, got, want);
    end
  endtask

  task automatic next_frame();
    if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      in_frame = 1'b1;
      k        = 0;
    end else begin
      in_frame = 1'b0;
    end
  endtask

  // Monitor: a frame begins after a reset edge or on a frame_start pulse
  always @(negedge clk) begin
    if (rst_d) begin
      check("reset_outputs", {sel, data_disp, dp, frame_start}, {4'hF, 4'h0, 1'b0, 1'b0});
      next_frame();
    end else if (in_frame) begin
      k++;
      check("scan", {1'b0, sel, data_disp, dp}, {1'b0, model(cur, k - 1)});
      check("frame_start", {9'b0, frame_start}, {9'b0, (k == FRAME)});
      if (k == FRAME) next_frame();
    end else if (frame_start) begin
      next_frame();
    end
  end

  task automatic goto(input int unsigned t);
    while (m < t) begin
      @(negedge clk);
      m++;
    end
  endtask

  task automatic load_at(input int unsigned t, input logic [15:0] v, input logic [3:0] d);
    goto(t);
    din       = v;
    dp_in     = d;
    din_valid = 1'b1;
    @(negedge clk);
    m++;
    din_valid = 1'b0;
  endtask

  function automatic frame_t fr(input logic [15:0] v, input logic [3:0] d);
    fr.val = v;
    fr.dpv = d;
  endfunction

  initial begin
    int unsigned guard;
    // Reset with a coincident strobe that must be ignored
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = 16'hDEAD;
    dp_in     = 4'hF;
    exp_q.push_back(fr(16'h0000, 4'h0));
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    dp_in     = '0;
    m         = 0;

    load_at(3, 16'h1234, 4'h0);
    exp_q.push_back(fr(16'h1234, 4'h0));
    load_at(43, 16'hABCD, 4'h0);            // mid-frame, digit 1
    exp_q.push_back(fr(16'hABCD, 4'h0));
    load_at(69, 16'h1111, 4'h0);
    load_at(84, 16'h2222, 4'h0);            // last strobe wins
    exp_q.push_back(fr(16'h2222, 4'h0));
    load_at(127, 16'h5555, 4'h0);           // on the boundary tick
    exp_q.push_back(fr(16'h5555, 4'h0));
    exp_q.push_back(fr(16'h5555, 4'h0));
    load_at(164, 16'h0987, 4'b0100);
    exp_q.push_back(fr(16'h0987, 4'b0100));
    load_at(202, 16'h0042, 4'h0);
    exp_q.push_back(fr(16'h0042, 4'h0));
    exp_q.push_back(fr(16'h0042, 4'h0));
    load_at(259, 16'h7777, 4'hF);           // pending, discarded by reset

    goto(275);                              // digit 2 of the frame
    rst = 1'b1;
    exp_q.push_back(fr(16'h0000, 4'h0));
    exp_q.push_back(fr(16'h0000, 4'h0));
    @(negedge clk);
    rst = 1'b0;
    m   = 0;

    guard = 0;
    while ((exp_q.size() != 0 || in_frame) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0 || in_frame) begin
      n_fail++;
      $display("FAIL drain: %0d frames left unchecked, in_frame=%0d, expected 0 and 0", exp_q.size(), in_frame);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per digit slot (minimum 4).
REQ-002 The block SHALL have parameter BLANK_CYC, default 500, meaning cycles at slot start with all digits off (anti-ghosting, 0 <= BLANK_CYC < CLK_DIV).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port din  input  16  four BCD/hex nibbles, din[3:0] = digit 0 (rightmost).
REQ-006 The block SHALL have port dp_in  input  4  decimal-point enables, bit i = digit i.
REQ-007 The block SHALL have port din_valid  input  1  single-cycle load strobe for din/dp_in.
REQ-008 The block SHALL have port data_disp  output  4  nibble for the external segment decoder.
REQ-009 The block SHALL have port sel  output  4  digit enables, active-low, bit i = digit i.
REQ-010 The block SHALL have port dp  output  1  decimal point of the currently selected digit, active-high.
REQ-011 The block SHALL have port frame_start  output  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-012 The block SHALL count div from 0 to CLK_DIV-1 and wrap; tick asserts when div == CLK_DIV-1.
REQ-013 The block SHALL advance digit index idx on tick, 0->1->2->3->0.
REQ-014 The block SHALL hold a pending register: din_valid captures din/dp_in into pending and sets pend_flag; a later din_valid before application overwrites (last wins).
REQ-015 The block SHALL copy pending into the active register and clear pend_flag only on tick with idx == 3 (frame boundary); no mid-frame change of displayed value.
REQ-016 When din_valid coincides with the frame-boundary tick, the block SHALL load din/dp_in directly into active and leave pend_flag clear.
REQ-017 The block SHALL drive sel = 4'b1111 while div < BLANK_CYC; otherwise sel = ~(1 << idx).
REQ-018 The block SHALL drive data_disp = active nibble idx and dp = active dp bit idx (dp forced 0 while sel is all off).
REQ-019 sel, data_disp, dp and frame_start SHALL be registered: outputs in cycle n+1 reflect div/idx/active of cycle n.
REQ-020 frame_start SHALL pulse high for exactly one cycle, one cycle after the tick that sets idx to 0.
REQ-021 With BLANK_CYC = 0 the block SHALL never blank between slots.

Reset
REQ-022 On rst high at a clock edge the block SHALL set div=0, idx=0, active=0, pending=0, pend_flag=0.
REQ-023 During reset and the cycle after, outputs SHALL be sel=4'b1111, data_disp=0, dp=0, frame_start=0.
REQ-024 rst asserted mid-frame SHALL discard any pending load; after release scanning restarts at digit 0 with div=0.
REQ-025 din_valid in the same cycle as rst SHALL be ignored.

Configuration
REQ-026 With macro SEG_ZERO_BLANK_EN defined the block SHALL suppress leading zeros: digit i (i = 3..1) keeps sel bit i high when active nibbles i..3 are all 0 and dp bit i is 0; digit 0 is always shown.
REQ-027 Without SEG_ZERO_BLANK_EN every digit SHALL be enabled in its slot regardless of value.

Verification (bench uses CLK_DIV=8, BLANK_CYC=2)
REQ-028 Reset release, din_valid with din=16'h1234 -> sel sequence 1110,1101,1011,0111 with data_disp 4,3,2,1 starting after next frame boundary; sel=1111 for first 2 cycles of each 8-cycle slot.
REQ-029 din=16'hABCD loaded while idx=1 -> digits 2,3 of current frame still show old value; new value from next frame_start.
REQ-030 Two din_valid strobes (16'h1111 then 16'h2222) in one frame -> only 2222 displayed; din_valid on boundary tick with 16'h5555 -> 5555 shown in the immediately following digit-0 slot.
REQ-031 rst pulsed during digit 2 with pending load -> sel=1111, then scan restarts at digit 0 showing 0000, pending discarded.
REQ-032 SEG_ZERO_BLANK_EN defined, din=16'h0042, dp_in=0 -> sel bits 3,2 stay high all frame; digits 1,0 show 4,2; undefined -> all four digits enabled, data_disp 2,4,0,0.
REQ-033 dp_in=4'b0100 -> dp=1 only in digit-2 unblanked cycles; frame_start period exactly 32 cycles.
